lsu_clken_gen: RTL and testbench

//  Parametrised clock-enable generator for an N-stage LSU pipeline plus NCHAN bus channels.

---
 rtl/lsu_clken_gen_pkg.sv | 18 +
 rtl/lsu_clken_gen_if.sv | 44 ++++
 rtl/lsu_clken_gen_holdctr.sv | 35 +++
 rtl/lsu_clken_gen.sv | 127 ++++++++++++
 tb/tb_lsu_clken_gen.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_clken_gen_pkg.sv
// Shared types for the LSU clock-enable generator: freeze FSM encoding,
// statistics counter width and a saturating increment helper.
package lsu_clken_gen_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FROZEN = 2'd1,
    THAW   = 2'd2
  } lsu_frz_e;

  localparam int STAT_W = 16;

  // Holds at all-ones instead of wrapping back to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lsu_clken_gen_if.sv
// Request/status bundle between the LSU control logic (master) and the
// clock-enable generator (slave).
interface lsu_clken_gen_if
  import lsu_clken_gen_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int NCHAN  = 2,
  parameter int HOLD_W = 4
);

  logic                       clk_override;
  logic                       freeze;
  logic                       dma_req;
  logic [NSTAGE-1:0]          stage_vld;
  logic [NSTAGE-1:0]          stage_store;
  logic [HOLD_W-1:0]          hold_cfg;
  logic [NCHAN-1:0]           chan_req;
  logic [NCHAN-1:0]           chan_busy;
  logic [NCHAN-1:0]           chan_clk_en;

  logic [NSTAGE-1:0]          c1_clken;
  logic [NSTAGE-1:0]          c2_clken;
  logic [NSTAGE-1:0]          store_clken;
  logic [NCHAN-1:0]           chan_clken;
  logic                       free_clken;
  logic                       idle;
  lsu_frz_e                   frz_state;
  logic [STAT_W*NSTAGE-1:0]   stat_gated_cnt;

  modport master (
    output clk_override, freeze, dma_req, stage_vld, stage_store, hold_cfg,
           chan_req, chan_busy, chan_clk_en,
    input  c1_clken, c2_clken, store_clken, chan_clken, free_clken, idle,
           frz_state, stat_gated_cnt
  );

  modport slave (
    input  clk_override, freeze, dma_req, stage_vld, stage_store, hold_cfg,
           chan_req, chan_busy, chan_clk_en,
    output c1_clken, c2_clken, store_clken, chan_clken, free_clken, idle,
           frz_state, stat_gated_cnt
  );

endinterface

// File: rtl/lsu_clken_gen_holdctr.sv
// Idle hold-off down-counter: reloads on activity, otherwise counts down and
// parks at zero. Only the nonzero flag leaves the block.
module lsu_clken_gen_holdctr #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [HOLD_W-1:0] load_val_i,
  output logic              nz_o
);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nz_o = (cnt_q != '0);

endmodule

// File: rtl/lsu_clken_gen.sv
// Clock-enable generator for an NSTAGE LSU pipeline and NCHAN bus channels,
// with freeze/thaw FSM and idle hold-off. Gated-cycle stats need RV_CLKEN_STATS_EN.
module lsu_clken_gen
  import lsu_clken_gen_pkg::*;
#(
  parameter int NSTAGE    = 5,
  parameter int FRZ_STAGE = 3,
  parameter int NCHAN     = 2,
  parameter int HOLD_W    = 4
) (
  input  logic           clk,
  input  logic           rst,
  lsu_clken_gen_if.slave bus
);

  lsu_frz_e          state_q;
  lsu_frz_e          state_d;
  logic [NSTAGE-1:0] c1_q;
  logic [NSTAGE-1:0] c1_d;
  logic              act;
  logic              act_q;
  logic              hold_nz;
  logic              free_en;
  logic              frz_active;
  logic              thaw_active;
  logic [NSTAGE-1:0] frz_mask;
  logic [NSTAGE-1:0] thaw_mask;
  logic [NSTAGE-1:0] ovr_vec;
  logic [NSTAGE-1:0] c1_raw;
  logic [NSTAGE-1:0] c1_en;
  logic [NSTAGE-1:0] c2_en;
  logic [NSTAGE-1:0] st_en;

  // Freeze acts in the same cycle it is requested, so the raw input is ORed
  // with the registered state; a reasserted freeze also overrides THAW.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.freeze)  state_d = FROZEN;
      FROZEN:  if (!bus.freeze) state_d = THAW;
      THAW:    state_d = bus.freeze ? FROZEN : RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    frz_active  = (state_q == FROZEN) || bus.freeze;
    thaw_active = (state_q == THAW);
    frz_mask    = '0;
    thaw_mask   = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      frz_mask[i]  = (i < FRZ_STAGE) && frz_active;
      thaw_mask[i] = (i < FRZ_STAGE) && thaw_active;
    end
  end

  assign act = (|bus.stage_vld) | bus.dma_req | (|bus.chan_busy) | (|bus.chan_req);

  lsu_clken_gen_holdctr #(
    .HOLD_W(HOLD_W)
  ) u_holdctr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (act),
    .load_val_i(bus.hold_cfg),
    .nz_o      (hold_nz)
  );

  assign free_en = act | act_q | hold_nz | bus.clk_override | (state_q != RUN);

  // Stage i is enabled by its own valid or by the stage-(i-1) enable seen
  // last cycle; DMA only enters at stage 0.
  always_comb begin
    ovr_vec = {NSTAGE{bus.clk_override}};
    c1_raw  = bus.stage_vld | {c1_q[NSTAGE-2:0], bus.dma_req};
    c1_en   = (c1_raw | ovr_vec | thaw_mask) & ~frz_mask;
    c2_en   = (c1_en | c1_q | ovr_vec) & ~frz_mask;
    st_en   = ((c1_en & bus.stage_store) | ovr_vec) & ~frz_mask;
    c1_d    = free_en ? c1_en : c1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      act_q   <= 1'b0;
      c1_q    <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act;
      c1_q    <= c1_d;
    end
  end

  assign bus.c1_clken    = c1_en;
  assign bus.c2_clken    = c2_en;
  assign bus.store_clken = st_en;
  assign bus.chan_clken  = ((bus.chan_req | bus.chan_busy) & bus.chan_clk_en)
                         | {NCHAN{bus.clk_override}};
  assign bus.free_clken  = free_en;
  assign bus.idle        = ~free_en;
  assign bus.frz_state   = state_q;

`ifdef RV_CLKEN_STATS_EN
  logic [STAT_W-1:0] stat_q [NSTAGE];

  // Counts cycles in which a stage's single-pulse enable was gated off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSTAGE; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (!c1_en[i]) stat_q[i] <= sat_inc(stat_q[i]);
      end
    end
  end

  always_comb begin
    bus.stat_gated_cnt = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      bus.stat_gated_cnt[STAT_W*i +: STAT_W] = stat_q[i];
    end
  end
`else
  assign bus.stat_gated_cnt = '0;
`endif

endmodule

// File: tb/tb_lsu_clken_gen.sv
// Bench for lsu_clken_gen: cycle vector table through a scoreboard queue,
// then hand sequences for hold_cfg reload timing and reset during freeze.
module tb_lsu_clken_gen;
  import lsu_clken_gen_pkg::*;

  localparam int NSTAGE    = 5;
  localparam int FRZ_STAGE = 3;
  localparam int NCHAN     = 2;
  localparam int HOLD_W    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lsu_clken_gen_if #(.NSTAGE(NSTAGE), .NCHAN(NCHAN), .HOLD_W(HOLD_W)) bus ();

  lsu_clken_gen #(
    .NSTAGE(NSTAGE), .FRZ_STAGE(FRZ_STAGE), .NCHAN(NCHAN), .HOLD_W(HOLD_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_pre;
    logic       ovr, frz, dma;
    logic [4:0] vld, st;
    logic [3:0] hold;
    logic [1:0] req, busy, cen;
    logic [4:0] c1, c2, sc;
    logic [1:0] ch;
    logic       free;
    logic [1:0] state;
  } vec_t;

  vec_t tbl[$];
  vec_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int idx, input logic [79:0] act,
                     input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, o, f, d, input logic [4:0] vld, st,
                     input logic [3:0] hold, input logic [1:0] req, busy, cen,
                     input logic [4:0] c1, c2, sc, input logic [1:0] ch,
                     input logic free, input logic [1:0] state);
    vec_t v;
    v.rst_pre = r; v.ovr = o; v.frz = f; v.dma = d;
    v.vld = vld; v.st = st; v.hold = hold;
    v.req = req; v.busy = busy; v.cen = cen;
    v.c1 = c1; v.c2 = c2; v.sc = sc; v.ch = ch; v.free = free; v.state = state;
    tbl.push_back(v);
  endtask

  task automatic zero_inputs();
    bus.clk_override = 1'b0; bus.freeze = 1'b0; bus.dma_req = 1'b0;
    bus.stage_vld = '0; bus.stage_store = '0; bus.hold_cfg = '0;
    bus.chan_req = '0; bus.chan_busy = '0; bus.chan_clk_en = '0;
  endtask

  task automatic drive(input vec_t v);
    bus.clk_override = v.ovr; bus.freeze = v.frz; bus.dma_req = v.dma;
    bus.stage_vld = v.vld; bus.stage_store = v.st; bus.hold_cfg = v.hold;
    bus.chan_req = v.req; bus.chan_busy = v.busy; bus.chan_clk_en = v.cen;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic do_reset();
    rst = 1'b1;
    zero_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vec_t        e;
    logic        exp_idle;
    logic [79:0] exp_stat;
    int          n;
    bit          done;

    // r o f d  vld      st       hold  req   busy  cen    c1       c2       sc       ch    fr st
    // quiescent after reset
    add(0,0,0,0, 5'b00000,5'b00000,4'd0, 2'b00,2'b00,2'b00, 5'b00000,5'b00000,5'b00000,2'b00,0,0);
    add(0,0,0,0, 5'b00000,5'b00000,4'd0, 2'b00,2'b00,2'b00, 5'b00000,5'b00000,5'b00000,2'b00,0,0);
    // stage_vld[0] pulse ripples down the pipe, hold_cfg=7
    add(0,0,0,0, 5'b00001,5'b10101,4'd7, 2'b00,2'b00,2'b00, 5'b00001,5'b00001,5'b00001,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b10101,4'd7, 2'b00,2'b00,2'b00, 5'b00010,5'b00011,5'b00000,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b10101,4'd7, 2'b00,2'b00,2'b00, 5'b00100,5'b00110,5'b00100,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b10101,4'd7, 2'b00,2'b00,2'b00, 5'b01000,5'b01100,5'b00000,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b10101,4'd7, 2'b00,2'b00,2'b00, 5'b10000,5'b11000,5'b10000,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b10101,4'd7, 2'b00,2'b00,2'b00, 5'b00000,5'b10000,5'b00000,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b10101,4'd7, 2'b00,2'b00,2'b00, 5'b00000,5'b00000,5'b00000,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b10101,4'd7, 2'b00,2'b00,2'b00, 5'b00000,5'b00000,5'b00000,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b10101,4'd7, 2'b00,2'b00,2'b00, 5'b00000,5'b00000,5'b00000,2'b00,0,0);
    // dma_req pulse, hold_cfg=5: free_clken high 6 cycles
    add(0,0,0,1, 5'b00000,5'b00000,4'd5, 2'b00,2'b00,2'b00, 5'b00001,5'b00001,5'b00000,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b00000,4'd5, 2'b00,2'b00,2'b00, 5'b00010,5'b00011,5'b00000,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b00000,4'd5, 2'b00,2'b00,2'b00, 5'b00100,5'b00110,5'b00000,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b00000,4'd5, 2'b00,2'b00,2'b00, 5'b01000,5'b01100,5'b00000,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b00000,4'd5, 2'b00,2'b00,2'b00, 5'b10000,5'b11000,5'b00000,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b00000,4'd5, 2'b00,2'b00,2'b00, 5'b00000,5'b10000,5'b00000,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b00000,4'd5, 2'b00,2'b00,2'b00, 5'b00000,5'b00000,5'b00000,2'b00,0,0);
    // chan_req pulse, hold_cfg=0: free_clken high 2 cycles
    add(0,0,0,0, 5'b00000,5'b00000,4'd0, 2'b01,2'b00,2'b11, 5'b00000,5'b00000,5'b00000,2'b01,1,0);
    add(0,0,0,0, 5'b00000,5'b00000,4'd0, 2'b00,2'b00,2'b11, 5'b00000,5'b00000,5'b00000,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b00000,4'd0, 2'b00,2'b00,2'b00, 5'b00000,5'b00000,5'b00000,2'b00,0,0);
    // busy channels follow chan_clk_en; override forces everything on
    add(0,0,0,0, 5'b00000,5'b00000,4'd0, 2'b00,2'b11,2'b11, 5'b00000,5'b00000,5'b00000,2'b11,1,0);
    add(0,0,0,0, 5'b00000,5'b00000,4'd0, 2'b00,2'b11,2'b00, 5'b00000,5'b00000,5'b00000,2'b00,1,0);
    add(0,0,0,0, 5'b00000,5'b00000,4'd0, 2'b00,2'b11,2'b10, 5'b00000,5'b00000,5'b00000,2'b10,1,0);
    add(0,1,0,0, 5'b00000,5'b00000,4'd0, 2'b00,2'b00,2'b00, 5'b11111,5'b11111,5'b11111,2'b11,1,0);
    // freeze 3 cycles with valids in stages 1 and 3
    add(1,0,0,0, 5'b01010,5'b11111,4'd7, 2'b00,2'b00,2'b00, 5'b01010,5'b01010,5'b01010,2'b00,1,0);
    add(0,0,1,0, 5'b01010,5'b11111,4'd7, 2'b00,2'b00,2'b00, 5'b11000,5'b11000,5'b11000,2'b00,1,0);
    add(0,0,1,0, 5'b01010,5'b11111,4'd7, 2'b00,2'b00,2'b00, 5'b11000,5'b11000,5'b11000,2'b00,1,1);
    add(0,0,1,0, 5'b01010,5'b11111,4'd7, 2'b00,2'b00,2'b00, 5'b11000,5'b11000,5'b11000,2'b00,1,1);
    add(0,0,0,0, 5'b01010,5'b11111,4'd7, 2'b00,2'b00,2'b00, 5'b11000,5'b11000,5'b11000,2'b00,1,1);
    add(0,0,0,0, 5'b01010,5'b11111,4'd7, 2'b00,2'b00,2'b00, 5'b11111,5'b11111,5'b11111,2'b00,1,2);
    add(0,0,0,0, 5'b00000,5'b00000,4'd7, 2'b00,2'b00,2'b00, 5'b11110,5'b11111,5'b00000,2'b00,1,0);
    // freeze re-asserted during THAW; override still masked by freeze
    add(1,0,1,0, 5'b00000,5'b00000,4'd0, 2'b00,2'b00,2'b00, 5'b00000,5'b00000,5'b00000,2'b00,0,0);
    add(0,0,0,0, 5'b00000,5'b00000,4'd0, 2'b00,2'b00,2'b00, 5'b00000,5'b00000,5'b00000,2'b00,1,1);
    add(0,0,1,0, 5'b00000,5'b00000,4'd0, 2'b00,2'b00,2'b00, 5'b00000,5'b00000,5'b00000,2'b00,1,2);
    add(0,1,0,0, 5'b00000,5'b00000,4'd0, 2'b00,2'b00,2'b00, 5'b11000,5'b11000,5'b11000,2'b11,1,1);
    add(0,0,0,0, 5'b00000,5'b00000,4'd0, 2'b00,2'b00,2'b00, 5'b10111,5'b11111,5'b00000,2'b00,1,2);
    add(0,0,0,0, 5'b00000,5'b00000,4'd0, 2'b00,2'b00,2'b00, 5'b01110,5'b11111,5'b00000,2'b00,0,0);

    zero_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Gated-cycle counters: cleared by reset, then count idle cycles if present.
    @(negedge clk);
    chk("stat_rst", 0, bus.stat_gated_cnt, 80'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef RV_CLKEN_STATS_EN
    exp_stat = {5{16'd3}};
`else
    exp_stat = '0;
`endif
    chk("stat_cnt", 0, bus.stat_gated_cnt, exp_stat);
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_pre) do_reset();
      drive(tbl[i]);
      sbq.push_back(tbl[i]);
      @(negedge clk);
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty vec %0d got 0 entries want 1", i);
      end else begin
        e = sbq.pop_front();
        exp_idle = ~e.free;
        chk("c1",    i, bus.c1_clken,    e.c1);
        chk("c2",    i, bus.c2_clken,    e.c2);
        chk("store", i, bus.store_clken, e.sc);
        chk("chan",  i, bus.chan_clken,  e.ch);
        chk("free",  i, bus.free_clken,  e.free);
        chk("idle",  i, bus.idle,        exp_idle);
        chk("state", i, bus.frz_state,   e.state);
      end
      @(posedge clk);
      #1;
    end

    // hold_cfg rewritten while counting down must not affect the current run.
    do_reset();
    bus.dma_req  = 1'b1;
    bus.hold_cfg = 4'd3;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (bus.free_clken) n++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      bus.dma_req  = 1'b0;
      bus.hold_cfg = 4'd9;
    end
    chk("hold_len", 0, n, 4);

    // Asynchronous reset while FROZEN with the hold counter at 7.
    do_reset();
    bus.freeze    = 1'b1;
    bus.stage_vld = 5'b00001;
    bus.hold_cfg  = 4'd7;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_state", 0, bus.frz_state, FROZEN);
    chk("pre_free",  0, bus.free_clken, 1'b1);
    chk("pre_c1",    0, bus.c1_clken, 5'b00000);
    #2;
    rst = 1'b1;
    zero_inputs();
    #1;
    chk("rst_state", 0, bus.frz_state, RUN);
    chk("rst_c1",    0, bus.c1_clken, 5'b00000);
    chk("rst_c2",    0, bus.c2_clken, 5'b00000);
    chk("rst_store", 0, bus.store_clken, 5'b00000);
    chk("rst_free",  0, bus.free_clken, 1'b0);
    chk("rst_idle",  0, bus.idle, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_free",  0, bus.free_clken, 1'b0);
    chk("post_state", 0, bus.frz_state, RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
